// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the BRAM word streamer.
// The FSM state encoding lives here so the top and any future debug taps agree.
package stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    GUARD,
    WAIT,
    NEXT
  } streamer_state_t;

  localparam int DEFAULT_WORD_WIDTH = 32;

  function automatic int bytes_per_word(input int word_width);
    return word_width / 8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DEFAULT_WORD_WIDTH);

endpackage

// File: rtl/word_byte_shifter.sv
// Holds one BRAM word and presents it a byte at a time, least significant first.
// WORD_WIDTH must be a multiple of 8.
module word_byte_shifter
  import stream_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic                  advance,
  output logic [7:0]            byte_out,
  output logic                  last_byte
);

  localparam int BPW   = bytes_per_word(WORD_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      idx;

  // NOTE: the shift register is ordinary flops, not a RAM, so it is reset
  // along with everything else; that keeps byte_out deterministic after reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
    end else if (advance) begin
      shreg <= shreg >> 8;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign byte_out  = shreg[7:0];
  assign last_byte = (idx == IDX_W'(BPW - 1));

endmodule

// File: rtl/bram_word_streamer.sv
// Readback stage: walks a BRAM address range, waits out the read latency and
// feeds each word to uart_transmit byte by byte over its trigger/busy handshake.
module bram_word_streamer
  import stream_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ADDR_WIDTH:0]   num_words_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_trigger_out,
  input  logic                  tx_busy_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [ADDR_WIDTH:0]   words_sent_out
);

  localparam int LAT_W = $clog2(READ_LATENCY + 2);

  streamer_state_t state, state_next;

  logic [ADDR_WIDTH:0] count_q;
  logic [LAT_W-1:0]    lat_cnt;
  logic [7:0]          cur_byte;
  logic                last_byte;

  logic load_start, zero_done, lat_inc, capture, fire;
  logic advance, word_done, addr_inc, finish;

  word_byte_shifter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_shifter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (capture),
    .word     (word_in),
    .advance  (advance),
    .byte_out (cur_byte),
    .last_byte(last_byte)
  );

  // NOTE: registers use <= so every flop samples pre-edge values; blocking
  // assignments here would make results depend on statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    zero_done  = 1'b0;
    lat_inc    = 1'b0;
    capture    = 1'b0;
    fire       = 1'b0;
    advance    = 1'b0;
    word_done  = 1'b0;
    addr_inc   = 1'b0;
    finish     = 1'b0;

    if (abort_in) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_in) begin
            if (num_words_in != '0) begin
              load_start = 1'b1;
              state_next = FETCH;
            end else begin
              zero_done = 1'b1;
            end
          end
        end
        // word_in is trusted only once the address has been stable READ_LATENCY+1 cycles
        FETCH: begin
          if (lat_cnt == LAT_W'(READ_LATENCY)) begin
            capture    = 1'b1;
            state_next = SEND;
          end else begin
            lat_inc = 1'b1;
          end
        end
        SEND: begin
          if (!tx_busy_in) begin
            fire       = 1'b1;
            state_next = GUARD;
          end
        end
        // The UART raises busy one cycle after it sees the trigger; skip that cycle.
        GUARD: state_next = WAIT;
        WAIT: begin
          if (!tx_busy_in) begin
            if (last_byte) begin
              word_done  = 1'b1;
              state_next = NEXT;
            end else begin
              advance    = 1'b1;
              state_next = SEND;
            end
          end
        end
        NEXT: begin
          if (words_sent_out == count_q) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            addr_inc   = 1'b1;
            state_next = FETCH;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_out       <= '0;
      count_q        <= '0;
      lat_cnt        <= '0;
      tx_byte_out    <= '0;
      tx_trigger_out <= 1'b0;
      done_out       <= 1'b0;
      words_sent_out <= '0;
    end else begin
      tx_trigger_out <= fire;
      done_out       <= zero_done | finish;
      lat_cnt        <= lat_inc ? lat_cnt + LAT_W'(1) : '0;

      if (load_start) begin
        addr_out       <= base_addr_in;
        count_q        <= num_words_in;
        words_sent_out <= '0;
      end
      if (addr_inc)  addr_out       <= addr_out + ADDR_WIDTH'(1);
      if (fire)      tx_byte_out    <= cur_byte;
      if (word_done) words_sent_out <= words_sent_out + (ADDR_WIDTH + 1)'(1);
    end
  end

  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_bram_word_streamer.sv
// Randomised bench for bram_word_streamer with BRAM and UART behavioural models;
// the expected byte stream is derived straight from memory contents and the LSB-first rule.
module tb_bram_word_streamer;

  localparam int WW = 32;
  localparam int AW = 2;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic [AW-1:0] base_addr_in = '0;
  logic [AW:0]   num_words_in = '0;
  logic [AW-1:0] addr_out;
  logic [WW-1:0] word_in = '0;
  logic [7:0]    tx_byte_out;
  logic          tx_trigger_out;
  logic          tx_busy_in;
  logic          busy_out;
  logic          done_out;
  logic [AW:0]   words_sent_out;

  bram_word_streamer #(
    .WORD_WIDTH  (WW),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .abort_in      (abort_in),
    .base_addr_in  (base_addr_in),
    .num_words_in  (num_words_in),
    .addr_out      (addr_out),
    .word_in       (word_in),
    .tx_byte_out   (tx_byte_out),
    .tx_trigger_out(tx_trigger_out),
    .tx_busy_in    (tx_busy_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .words_sent_out(words_sent_out)
  );

  // BRAM model: two registered stages, so data follows the address by two cycles
  logic [WW-1:0] mem [4];
  logic [WW-1:0] rd_stage = '0;
  initial begin
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    mem[2] = 32'hCCBBAA99;
    mem[3] = 32'h00FFEEDD;
  end
  always @(posedge clk) begin
    rd_stage <= mem[addr_out];
    word_in  <= rd_stage;
  end

  // UART model: busy from the cycle after a trigger, for 20 cycles
  int   busy_cnt = 0;
  logic ext_hold = 1'b0;
  logic noise_hold = 1'b0;
  always @(posedge clk) begin
    if (tx_trigger_out)    busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy_in = (busy_cnt != 0) || ext_hold || noise_hold;

  logic noise_en = 1'b0;
  always @(negedge clk) noise_hold <= noise_en && ($urandom_range(0, 9) == 0);

  // Monitor
  int        cyc = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int        trig_cnt, done_cnt, consec, last_trig, min_gap;
  logic      prev_trig = 1'b0;
  logic      busy_seen;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_trigger_out) begin
      obs_q.push_back(tx_byte_out);
      trig_cnt++;
      if (prev_trig) consec++;
      if (last_trig >= 0 && (cyc - last_trig) < min_gap) min_gap = cyc - last_trig;
      last_trig = cyc;
    end
    prev_trig = tx_trigger_out;
    if (done_out) done_cnt++;
    if (busy_out) busy_seen = 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic reset_mon();
    obs_q.delete();
    exp_q.delete();
    trig_cnt  = 0;
    done_cnt  = 0;
    last_trig = -1;
    min_gap   = 1000000;
    busy_seen = 1'b0;
  endtask

  // Reference: word w of the range sits at (base + w) mod 4; bytes go out LSB first
  task automatic build_expected(input int base, input int n);
    for (int w = 0; w < n; w++) begin
      int unsigned word;
      word = mem[(base + w) % 4];
      for (int k = 0; k < WW / 8; k++) exp_q.push_back(8'((word >> (8 * k)) & 32'hFF));
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic pulse_start(input int base, input int n);
    @(negedge clk);
    base_addr_in = AW'(base);
    num_words_in = (AW + 1)'(n);
    start_in     = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    repeat (2) @(negedge clk);
    check({tag, "_done_once_after"}, done_cnt, 1);
  endtask

  task automatic wait_uart_idle();
    for (int i = 0; i < 200 && tx_busy_in; i++) @(negedge clk);
  endtask

  initial begin
    consec = 0;
    reset_mon();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", addr_out, 0);
    check("rst_byte", tx_byte_out, 0);
    check("rst_trig", tx_trigger_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_ws", words_sent_out, 0);
    rst_in = 1'b0;

    // Basic transfer
    reset_mon();
    build_expected(0, 2);
    pulse_start(0, 2);
    wait_done("basic");
    compare_stream("basic");
    check("basic_ntrig", trig_cnt, 8);
    check("basic_ws", words_sent_out, 2);
    check("basic_addr", addr_out, 1);
    check("basic_gap_ge22", min_gap >= 22, 1);
    check("basic_idle", busy_out, 0);
    wait_uart_idle();

    // Zero count
    reset_mon();
    pulse_start(2, 0);
    check("zero_done_pulse", done_out, 1);
    @(negedge clk);
    check("zero_done_low", done_out, 0);
    repeat (5) @(negedge clk);
    check("zero_ntrig", trig_cnt, 0);
    check("zero_busy_seen", busy_seen, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Address wrap: 3 then 0
    reset_mon();
    build_expected(3, 2);
    pulse_start(3, 2);
    wait_done("wrap");
    compare_stream("wrap");
    check("wrap_ws", words_sent_out, 2);
    check("wrap_addr", addr_out, 0);
    wait_uart_idle();

    // Abort after the 6th trigger
    reset_mon();
    pulse_start(0, 3);
    for (int i = 0; i < 3000 && trig_cnt < 6; i++) @(negedge clk);
    check("abort_reached6", trig_cnt, 6);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    check("abort_idle", busy_out, 0);
    repeat (100) @(negedge clk);
    check("abort_ntrig", trig_cnt, 6);
    check("abort_no_done", done_cnt, 0);
    check("abort_ws", words_sent_out, 1);
    wait_uart_idle();

    // Busy stall with an ignored start
    reset_mon();
    build_expected(1, 1);
    ext_hold = 1'b1;
    pulse_start(1, 1);
    repeat (50) @(negedge clk);
    pulse_start(2, 3);
    repeat (50) @(negedge clk);
    check("stall_ntrig", trig_cnt, 0);
    check("stall_busy", busy_out, 1);
    ext_hold = 1'b0;
    @(negedge clk);
    check("stall_trig_next", tx_trigger_out, 1);
    wait_done("stall");
    compare_stream("stall");
    check("stall_ws", words_sent_out, 1);
    check("stall_addr", addr_out, 1);
    wait_uart_idle();

    // Reset mid-transfer
    reset_mon();
    pulse_start(0, 3);
    repeat (40) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy_out, 0);
    check("midrst_addr", addr_out, 0);
    check("midrst_ws", words_sent_out, 0);
    check("midrst_byte", tx_byte_out, 0);
    check("midrst_trig", tx_trigger_out, 0);
    rst_in = 1'b0;
    wait_uart_idle();

    // Random transfers with random extra busy stalls
    noise_en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int base, n;
      base = $urandom_range(0, 3);
      n    = $urandom_range(0, 5);
      reset_mon();
      build_expected(base, n);
      pulse_start(base, n);
      wait_done($sformatf("rnd%0d", t));
      compare_stream($sformatf("rnd%0d", t));
      check($sformatf("rnd%0d_gap_ge22", t), (n < 1) || (min_gap >= 22), 1);
      if (n > 0) begin
        check($sformatf("rnd%0d_ws", t), words_sent_out, n);
        check($sformatf("rnd%0d_addr", t), addr_out, (base + n - 1) % 4);
      end
      wait_uart_idle();
    end
    noise_en = 1'b0;

    check("no_back_to_back_trig", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
